// File: rtl/instruction_fetch.sv
// ============================================================================
// Module: instruction_fetch
//
// Purpose
//   Front end of the CPU. Holds the program counter. Fetches instruction
//   words from memory over a simple request/acknowledge handshake. Each word
//   is latched into an instruction register (IR) and presented to the
//   next-state logic as opcode / rx / ry, qualified by instr_valid.
//   The fetcher advances to the next address when the CPU reports DONE.
//   It stops for good when a terminate instruction meets the CPU's
//   terminate state.
//
// Ports
//   clk              : rising-edge clock
//   rst_n            : asynchronous active-low reset
//   run              : start pulse, only honoured while idle
//   cpu_state        : current CPU state code
//   mem_req          : fetch request to memory
//   mem_addr         : fetch address, always equal to pc
//   mem_ack          : memory has valid data on mem_rdata this cycle
//   mem_rdata        : fetched instruction word
//   instruction_code : IR opcode field [8:6]
//   rx               : IR register field [5:3]
//   ry               : IR register field [2:0]
//   instr_valid      : IR holds a fetched instruction not yet retired
//   pc               : current program counter
//   halted           : sticky terminate flag, cleared only by reset
// ============================================================================
module instruction_fetch #(
  parameter int         PC_W    = 4,
  parameter int         IW      = 9,
  parameter logic [3:0] ST_DONE = 4'b1111,
  parameter logic [3:0] ST_TERM = 4'b0110,
  parameter logic [2:0] OP_TERM = 3'b100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [3:0]      cpu_state,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [IW-1:0]   mem_rdata,
  output logic [2:0]      instruction_code,
  output logic [2:0]      rx,
  output logic [2:0]      ry,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_VALID,
    F_HALT
  } fetch_state_t;

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [IW-1:0] ir;
  logic          ir_load;
  logic          pc_advance;
  logic          is_term_op;

  // The opcode test looks at the latched IR, not the memory bus.
  // Terminate is therefore judged on the instruction the CPU is executing.
  assign is_term_op = (ir[IW-1 -: 3] == OP_TERM);

  // The decoded fields come straight off the IR register, so they are
  // registered outputs. During a fetch they keep showing the previous
  // instruction. Consumers must qualify them with instr_valid.
  assign instruction_code = ir[IW-1 -: 3];
  assign rx               = ir[5:3];
  assign ry               = ir[2:0];

  // The fetch address is the program counter itself. pc only changes on the
  // DONE advance out of F_VALID, so the address is stable while a request
  // is outstanding.
  assign mem_addr = pc;

  // Next-state logic.
  // mem_ack is only examined in F_REQ, so stray acks in other states are
  // discarded. Every visit to F_VALID leaves on its first DONE. That is why
  // a DONE held for several cycles advances pc exactly once. Terminate
  // needs both the TERM opcode in IR and the CPU sitting in its terminate
  // state. pc is not advanced on that path.
  always_comb begin
    state_next = state;
    ir_load    = 1'b0;
    pc_advance = 1'b0;
    case (state)
      F_IDLE: begin
        if (run) begin
          state_next = F_REQ;
        end
      end
      F_REQ: begin
        if (mem_ack) begin
          ir_load    = 1'b1;
          state_next = F_VALID;
        end
      end
      F_VALID: begin
        if (is_term_op && (cpu_state == ST_TERM)) begin
          state_next = F_HALT;
        end else if (cpu_state == ST_DONE) begin
          pc_advance = 1'b1;
          state_next = F_REQ;
        end
      end
      F_HALT: begin
        state_next = F_HALT;
      end
      default: begin
        state_next = F_IDLE;
      end
    endcase
  end

  // State register plus all registered outputs.
  // mem_req, instr_valid and halted are computed from the next state.
  // They therefore change on the same edge as the state transition:
  //  - run at edge N raises mem_req after N.
  //  - an ack sampled at N+1 drops mem_req and raises instr_valid after N+1.
  // Reset is asynchronous. It drops mem_req immediately, even in the middle
  // of a fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= F_IDLE;
      pc          <= '0;
      ir          <= '0;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_next;
      mem_req     <= (state_next == F_REQ);
      instr_valid <= (state_next == F_VALID) || (state_next == F_HALT);
      halted      <= (state_next == F_HALT);
      if (ir_load) begin
        ir <= mem_rdata;
      end
      if (pc_advance) begin
        pc <= pc + PC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Testbench: tb_instruction_fetch
//
// Purpose
//   Directed, self-checking bench for instruction_fetch.
//   Covers the following behaviour:
//    - asynchronous reset in the middle of a fetch;
//    - the fetch handshake and its latency;
//    - a single pc advance on a held DONE;
//    - pc wrap-around;
//    - terminate and the halt that follows it;
//    - acks outside F_REQ being ignored.
//   All expected values are hand-computed constants.
// ============================================================================
module tb_instruction_fetch;

  localparam logic [3:0] ST_DONE = 4'b1111;
  localparam logic [3:0] ST_TERM = 4'b0110;
  localparam logic [3:0] ST_NONE = 4'b0000;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [3:0] cpu_state;
  logic       mem_req;
  logic [3:0] mem_addr;
  logic       mem_ack;
  logic [8:0] mem_rdata;
  logic [2:0] instruction_code;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       instr_valid;
  logic [3:0] pc;
  logic       halted;

  int testCount = 0;
  int failCount = 0;

  instruction_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .run              (run),
    .cpu_state        (cpu_state),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata),
    .instruction_code (instruction_code),
    .rx               (rx),
    .ry               (ry),
    .instr_valid      (instr_valid),
    .pc               (pc),
    .halted           (halted)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs. Wait for the edge, then settle 1 ns so that
  // outputs are sampled away from the edge.
  task automatic applyStimulus(input logic r, input logic [3:0] cs,
                               input logic ack, input logic [8:0] rdata);
    run       = r;
    cpu_state = cs;
    mem_ack   = ack;
    mem_rdata = rdata;
    @(posedge clk);
    #1;
  endtask

  // Check the control outputs in one call.
  task automatic checkControl(input string tag, input logic req,
                              input logic valid, input logic hlt,
                              input logic [3:0] exp_pc);
    checkOutput({tag, ".mem_req"},     32'(mem_req),     32'(req));
    checkOutput({tag, ".instr_valid"}, 32'(instr_valid), 32'(valid));
    checkOutput({tag, ".halted"},      32'(halted),      32'(hlt));
    checkOutput({tag, ".pc"},          32'(pc),          32'(exp_pc));
    checkOutput({tag, ".mem_addr"},    32'(mem_addr),    32'(exp_pc));
  endtask

  // Check the decoded instruction fields in one call.
  task automatic checkFields(input string tag, input logic [2:0] op,
                             input logic [2:0] ex, input logic [2:0] ey);
    checkOutput({tag, ".code"}, 32'(instruction_code), 32'(op));
    checkOutput({tag, ".rx"},   32'(rx),               32'(ex));
    checkOutput({tag, ".ry"},   32'(ry),               32'(ey));
  endtask

  // Main directed sequence.
  initial begin
    rst_n     = 1'b0;
    run       = 1'b0;
    cpu_state = ST_NONE;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #1;
    checkControl("reset", 1'b0, 1'b0, 1'b0, 4'd0);
    checkFields("reset", 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // An ack while idle must not load IR.
    applyStimulus(1'b0, ST_NONE, 1'b1, 9'h1FF);
    checkControl("idle_ack", 1'b0, 1'b0, 1'b0, 4'd0);
    checkFields("idle_ack", 3'd0, 3'd0, 3'd0);

    // Quick fetch, advance, then async reset mid-request.
    applyStimulus(1'b1, ST_NONE, 1'b0, 9'h000);
    checkControl("pre_req", 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, ST_NONE, 1'b1, 9'b011_101_110);
    checkControl("pre_valid", 1'b0, 1'b1, 1'b0, 4'd0);
    checkFields("pre_valid", 3'd3, 3'd5, 3'd6);
    applyStimulus(1'b0, ST_DONE, 1'b0, 9'h000);
    checkControl("pre_adv", 1'b1, 1'b0, 1'b0, 4'd1);
    checkFields("pre_adv_keep", 3'd3, 3'd5, 3'd6);
    mem_ack   = 1'b1;
    mem_rdata = 9'h1FF;
    rst_n     = 1'b0;
    #1;
    checkControl("mid_reset", 1'b0, 1'b0, 1'b0, 4'd0);
    checkFields("mid_reset", 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    rst_n   = 1'b1;
    applyStimulus(1'b0, ST_NONE, 1'b0, 9'h000);
    checkControl("post_reset_idle", 1'b0, 1'b0, 1'b0, 4'd0);

    // Fetch with the ack three cycles after the request.
    applyStimulus(1'b1, ST_NONE, 1'b0, 9'h000);
    checkControl("t2_req0", 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, ST_NONE, 1'b0, 9'h000);
    checkControl("t2_req1", 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, ST_NONE, 1'b0, 9'h000);
    checkControl("t2_req2", 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, ST_NONE, 1'b1, 9'b010_001_010);
    checkControl("t2_valid", 1'b0, 1'b1, 1'b0, 4'd0);
    checkFields("t2_valid", 3'd2, 3'd1, 3'd2);

    // In F_VALID, a stray ack and a run pulse must change nothing.
    applyStimulus(1'b0, ST_NONE, 1'b1, 9'h1FF);
    checkControl("t6_valid_ack", 1'b0, 1'b1, 1'b0, 4'd0);
    checkFields("t6_valid_ack", 3'd2, 3'd1, 3'd2);
    applyStimulus(1'b1, ST_NONE, 1'b0, 9'h000);
    checkControl("t6_valid_run", 1'b0, 1'b1, 1'b0, 4'd0);

    // Step pc from 0 to 3 with DONE followed by a one-cycle fetch.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, ST_DONE, 1'b0, 9'h000);
      applyStimulus(1'b0, ST_NONE, 1'b1, 9'b001_010_011);
    end
    checkControl("t3_at3", 1'b0, 1'b1, 1'b0, 4'd3);
    checkFields("t3_at3", 3'd1, 3'd2, 3'd3);

    // DONE held for three cycles advances pc exactly once.
    applyStimulus(1'b0, ST_DONE, 1'b0, 9'h000);
    checkControl("t3_done1", 1'b1, 1'b0, 1'b0, 4'd4);
    applyStimulus(1'b0, ST_DONE, 1'b0, 9'h000);
    checkControl("t3_done2", 1'b1, 1'b0, 1'b0, 4'd4);
    applyStimulus(1'b0, ST_DONE, 1'b0, 9'h000);
    checkControl("t3_done3", 1'b1, 1'b0, 1'b0, 4'd4);
    checkFields("t3_keep_ir", 3'd1, 3'd2, 3'd3);
    applyStimulus(1'b0, ST_NONE, 1'b1, 9'b110_111_000);
    checkControl("t3_valid4", 1'b0, 1'b1, 1'b0, 4'd4);
    checkFields("t3_valid4", 3'd6, 3'd7, 3'd0);

    // Walk pc up to F, then wrap it to 0.
    for (int i = 5; i <= 15; i++) begin
      applyStimulus(1'b0, ST_DONE, 1'b0, 9'h000);
      applyStimulus(1'b0, ST_NONE, 1'b1, 9'b000_001_001);
    end
    checkControl("t4_atF", 1'b0, 1'b1, 1'b0, 4'hF);
    applyStimulus(1'b0, ST_DONE, 1'b0, 9'h000);
    checkControl("t4_wrap", 1'b1, 1'b0, 1'b0, 4'd0);

    // Fetch TERM, then terminate.
    applyStimulus(1'b0, ST_NONE, 1'b1, 9'b100_000_000);
    checkControl("t5_term_valid", 1'b0, 1'b1, 1'b0, 4'd0);
    checkFields("t5_term_valid", 3'd4, 3'd0, 3'd0);
    applyStimulus(1'b0, ST_TERM, 1'b0, 9'h000);
    checkControl("t5_halt", 1'b0, 1'b1, 1'b1, 4'd0);

    // After halt, run, DONE and acks must all be ignored.
    applyStimulus(1'b1, ST_NONE, 1'b0, 9'h000);
    checkControl("t5_run", 1'b0, 1'b1, 1'b1, 4'd0);
    applyStimulus(1'b0, ST_DONE, 1'b0, 9'h000);
    checkControl("t5_done", 1'b0, 1'b1, 1'b1, 4'd0);
    applyStimulus(1'b0, ST_NONE, 1'b1, 9'h1FF);
    checkControl("t5_ack", 1'b0, 1'b1, 1'b1, 4'd0);
    checkFields("t5_ack", 3'd4, 3'd0, 3'd0);

    // Only reset leaves the halt state.
    rst_n = 1'b0;
    #1;
    checkControl("halt_reset", 1'b0, 1'b0, 1'b0, 4'd0);
    checkFields("halt_reset", 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, ST_NONE, 1'b0, 9'h000);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
